// File: rtl/single_to_double_write_packer_if.sv
// Write-side bus of the single-to-double packer: word writes in, packed pair writes out.
// The slave modport is the packer itself; the master modport is whoever drives words and observes pairs.
interface single_to_double_write_packer_if #(
    parameter int SINGLE_MEM_WIDTH = 32,
    parameter int SINGLE_MEM_DEPTH = 14,
    parameter int DOUBLE_MEM_WIDTH = 2 * SINGLE_MEM_WIDTH,
    parameter int DOUBLE_MEM_DEPTH = (SINGLE_MEM_DEPTH + 1) / 2
);
    localparam int SA_W = (SINGLE_MEM_DEPTH > 1) ? $clog2(SINGLE_MEM_DEPTH) : 1;
    localparam int DA_W = (DOUBLE_MEM_DEPTH > 1) ? $clog2(DOUBLE_MEM_DEPTH) : 1;

    logic                        single_mem_wr_en;
    logic [SA_W-1:0]             single_mem_wr_addr;
    logic [SINGLE_MEM_WIDTH-1:0] single_mem_din;
    logic                        single_mem_flush;
    logic                        double_mem_wr_en;
    logic [DA_W-1:0]             double_mem_wr_addr;
    logic [DOUBLE_MEM_WIDTH-1:0] double_mem_din;
    logic                        pack_done;
    logic                        pack_err;

    modport slave (
        input  single_mem_wr_en, single_mem_wr_addr, single_mem_din, single_mem_flush,
        output double_mem_wr_en, double_mem_wr_addr, double_mem_din, pack_done, pack_err
    );

    modport master (
        output single_mem_wr_en, single_mem_wr_addr, single_mem_din, single_mem_flush,
        input  double_mem_wr_en, double_mem_wr_addr, double_mem_din, pack_done, pack_err
    );
endinterface

// File: rtl/single_to_double_write_packer.sv
// Packs even/odd single-width word writes into one double-width write: even word in the
// upper half, odd word in the lower half, so the matching read wrapper sees the same layout.
module single_to_double_write_packer #(
    parameter int SINGLE_MEM_WIDTH = 32,
    parameter int SINGLE_MEM_DEPTH = 14,
    parameter int DOUBLE_MEM_WIDTH = 2 * SINGLE_MEM_WIDTH,
    parameter int DOUBLE_MEM_DEPTH = (SINGLE_MEM_DEPTH + 1) / 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    single_to_double_write_packer_if.slave         bus
);
    localparam int SA_W = (SINGLE_MEM_DEPTH > 1) ? $clog2(SINGLE_MEM_DEPTH) : 1;
    localparam int DA_W = (DOUBLE_MEM_DEPTH > 1) ? $clog2(DOUBLE_MEM_DEPTH) : 1;
    localparam logic [DA_W-1:0] LAST_PAIR = DA_W'(DOUBLE_MEM_DEPTH - 1);
    localparam bit ODD_DEPTH = (SINGLE_MEM_DEPTH % 2) == 1;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t                      r_state;
    logic [SINGLE_MEM_WIDTH-1:0] r_hi;
    logic [DA_W-1:0]             r_pair;
    logic                        r_wr_en;
    logic [DA_W-1:0]             r_wr_addr;
    logic [DOUBLE_MEM_WIDTH-1:0] r_din;
    logic                        r_done;
    logic                        r_err;

    state_t                      w_state_nxt;
    logic [SINGLE_MEM_WIDTH-1:0] w_hi_nxt;
    logic [DA_W-1:0]             w_pair_nxt;
    logic                        w_emit;
    logic [DOUBLE_MEM_WIDTH-1:0] w_emit_data;
    logic                        w_err_set;
    logic [DA_W-1:0]             w_p;
    logic                        w_odd;
    logic                        w_terminal;

    assign w_p        = bus.single_mem_wr_addr[SA_W-1:1];
    assign w_odd      = bus.single_mem_wr_addr[0];
    // The last word of an odd-depth operand never gets a partner, so it flushes itself.
    assign w_terminal = ODD_DEPTH && (r_pair == LAST_PAIR);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi;
        w_pair_nxt  = r_pair;
        w_emit      = 1'b0;
        w_emit_data = {r_hi, {SINGLE_MEM_WIDTH{1'b0}}};
        w_err_set   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (bus.single_mem_wr_en) begin
                    if (w_odd) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_hi_nxt    = bus.single_mem_din;
                        w_pair_nxt  = w_p;
                        w_state_nxt = HALF;
                    end
                end
            end
            HALF: begin
                if (bus.single_mem_wr_en) begin
                    w_emit = 1'b1;
                    if (w_odd) begin
                        w_state_nxt = EMPTY;
                        if (w_p == r_pair) begin
                            w_emit_data = {r_hi, bus.single_mem_din};
                        end else begin
                            w_err_set = 1'b1;
                        end
                    end else begin
                        w_hi_nxt   = bus.single_mem_din;
                        w_pair_nxt = w_p;
                    end
                end else if (bus.single_mem_flush || w_terminal) begin
                    w_emit      = 1'b1;
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= EMPTY;
            r_hi      <= '0;
            r_pair    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_din     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hi    <= w_hi_nxt;
            r_pair  <= w_pair_nxt;
            r_wr_en <= w_emit;
            r_done  <= w_emit && (r_pair == LAST_PAIR);
            r_err   <= r_err | w_err_set;
            if (w_emit) begin
                r_wr_addr <= r_pair;
                r_din     <= w_emit_data;
            end
        end
    end

    assign bus.double_mem_wr_en   = r_wr_en;
    assign bus.double_mem_wr_addr = r_wr_addr;
    assign bus.double_mem_din     = r_din;
    assign bus.pack_done          = r_done;
    assign bus.pack_err           = r_err;
endmodule

// File: tb/tb_single_to_double_write_packer.sv
// Directed bench for the write packer: one instance at even depth 14, one at odd depth 15.
module tb_single_to_double_write_packer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    single_to_double_write_packer_if #(.SINGLE_MEM_WIDTH(32), .SINGLE_MEM_DEPTH(14)) if14 ();
    single_to_double_write_packer_if #(.SINGLE_MEM_WIDTH(32), .SINGLE_MEM_DEPTH(15)) if15 ();

    single_to_double_write_packer #(.SINGLE_MEM_WIDTH(32), .SINGLE_MEM_DEPTH(14)) dut14 (
        .clk (clk),
        .rst (rst),
        .bus (if14.slave)
    );

    single_to_double_write_packer #(.SINGLE_MEM_WIDTH(32), .SINGLE_MEM_DEPTH(15)) dut15 (
        .clk (clk),
        .rst (rst),
        .bus (if15.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive14(input logic en, input logic [3:0] addr, input logic [31:0] din,
                           input logic flush);
        if14.single_mem_wr_en   = en;
        if14.single_mem_wr_addr = addr;
        if14.single_mem_din     = din;
        if14.single_mem_flush   = flush;
    endtask

    task automatic drive15(input logic en, input logic [3:0] addr, input logic [31:0] din);
        if15.single_mem_wr_en   = en;
        if15.single_mem_wr_addr = addr;
        if15.single_mem_din     = din;
        if15.single_mem_flush   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        drive14(1'b0, 4'd0, 32'h0, 1'b0);
        drive15(1'b0, 4'd0, 32'h0);

        // Reset state
        cyc();
        cyc();
        check("rst14_wr_en", 64'(if14.double_mem_wr_en), 64'd0);
        check("rst14_addr",  64'(if14.double_mem_wr_addr), 64'd0);
        check("rst14_din",   if14.double_mem_din, 64'd0);
        check("rst14_done",  64'(if14.pack_done), 64'd0);
        check("rst14_err",   64'(if14.pack_err), 64'd0);
        check("rst15_wr_en", 64'(if15.double_mem_wr_en), 64'd0);
        rst = 1'b1;
        cyc();

        // Depth 14: words 0..13 back to back, a pair emitted one cycle after each odd word
        for (int i = 0; i < 14; i++) begin
            drive14(1'b1, 4'(i), 32'h100 + 32'(i), 1'b0);
            cyc();
            if (i % 2 == 1) begin
                check("s14_wr_en", 64'(if14.double_mem_wr_en), 64'd1);
                check("s14_addr",  64'(if14.double_mem_wr_addr), 64'(i / 2));
                check("s14_din",   if14.double_mem_din,
                      {32'h100 + 32'(i - 1), 32'h100 + 32'(i)});
                check("s14_done",  64'(if14.pack_done), (i == 13) ? 64'd1 : 64'd0);
            end else begin
                check("s14_idle",  64'(if14.double_mem_wr_en), 64'd0);
            end
        end
        drive14(1'b0, 4'd0, 32'h0, 1'b0);
        cyc();
        check("s14_after_wr_en", 64'(if14.double_mem_wr_en), 64'd0);
        check("s14_after_done",  64'(if14.pack_done), 64'd0);
        check("s14_err",         64'(if14.pack_err), 64'd0);

        // Depth 15: pairs 0..6, then word 14 auto-flushes as pair 7 two cycles later
        for (int i = 0; i < 15; i++) begin
            drive15(1'b1, 4'(i), 32'h100 + 32'(i));
            cyc();
            if (i % 2 == 1) begin
                check("s15_wr_en", 64'(if15.double_mem_wr_en), 64'd1);
                check("s15_addr",  64'(if15.double_mem_wr_addr), 64'(i / 2));
                check("s15_din",   if15.double_mem_din,
                      {32'h100 + 32'(i - 1), 32'h100 + 32'(i)});
                check("s15_done",  64'(if15.pack_done), 64'd0);
            end else begin
                check("s15_idle",  64'(if15.double_mem_wr_en), 64'd0);
            end
        end
        drive15(1'b0, 4'd0, 32'h0);
        cyc();
        check("term15_wr_en", 64'(if15.double_mem_wr_en), 64'd1);
        check("term15_addr",  64'(if15.double_mem_wr_addr), 64'd7);
        check("term15_din",   if15.double_mem_din, {32'h10E, 32'h0});
        check("term15_done",  64'(if15.pack_done), 64'd1);
        cyc();
        check("term15_quiet", 64'(if15.double_mem_wr_en), 64'd0);
        check("term15_ndone", 64'(if15.pack_done), 64'd0);
        check("term15_hold",  64'(if15.double_mem_wr_addr), 64'd7);
        check("term15_err",   64'(if15.pack_err), 64'd0);

        // Orphan odd word in EMPTY
        drive14(1'b1, 4'd3, 32'h77, 1'b0);
        cyc();
        check("orph_wr_en", 64'(if14.double_mem_wr_en), 64'd0);
        check("orph_err",   64'(if14.pack_err), 64'd1);
        drive14(1'b0, 4'd0, 32'h0, 1'b0);
        cyc();
        check("orph_sticky", 64'(if14.pack_err), 64'd1);

        // Even 2, even 4 (pushes out half pair 1), odd 5 completes pair 2
        drive14(1'b1, 4'd2, 32'hA, 1'b0);
        cyc();
        check("ee_first_idle", 64'(if14.double_mem_wr_en), 64'd0);
        drive14(1'b1, 4'd4, 32'hB, 1'b0);
        cyc();
        check("ee_wr_en", 64'(if14.double_mem_wr_en), 64'd1);
        check("ee_addr",  64'(if14.double_mem_wr_addr), 64'd1);
        check("ee_din",   if14.double_mem_din, {32'hA, 32'h0});
        drive14(1'b1, 4'd5, 32'hC, 1'b0);
        cyc();
        check("eo_wr_en", 64'(if14.double_mem_wr_en), 64'd1);
        check("eo_addr",  64'(if14.double_mem_wr_addr), 64'd2);
        check("eo_din",   if14.double_mem_din, {32'hB, 32'hC});
        drive14(1'b0, 4'd0, 32'h0, 1'b0);
        cyc();
        check("hold_wr_en", 64'(if14.double_mem_wr_en), 64'd0);
        check("hold_addr",  64'(if14.double_mem_wr_addr), 64'd2);
        check("hold_din",   if14.double_mem_din, {32'hB, 32'hC});

        // Even 6, idle, flush pulse; then flush in EMPTY does nothing
        drive14(1'b1, 4'd6, 32'hD, 1'b0);
        cyc();
        check("fl_latch", 64'(if14.double_mem_wr_en), 64'd0);
        drive14(1'b0, 4'd0, 32'h0, 1'b0);
        cyc();
        check("fl_wait", 64'(if14.double_mem_wr_en), 64'd0);
        drive14(1'b0, 4'd0, 32'h0, 1'b1);
        cyc();
        check("fl_wr_en", 64'(if14.double_mem_wr_en), 64'd1);
        check("fl_addr",  64'(if14.double_mem_wr_addr), 64'd3);
        check("fl_din",   if14.double_mem_din, {32'hD, 32'h0});
        check("fl_done",  64'(if14.pack_done), 64'd0);
        cyc();
        check("fl_empty", 64'(if14.double_mem_wr_en), 64'd0);

        // Mismatched odd word emits the held half pair only
        drive14(1'b1, 4'd8, 32'h11, 1'b0);
        cyc();
        check("mm_latch", 64'(if14.double_mem_wr_en), 64'd0);
        drive14(1'b1, 4'd11, 32'h22, 1'b0);
        cyc();
        check("mm_wr_en", 64'(if14.double_mem_wr_en), 64'd1);
        check("mm_addr",  64'(if14.double_mem_wr_addr), 64'd4);
        check("mm_din",   if14.double_mem_din, {32'h11, 32'h0});

        // Flush is ignored while a write is present
        drive14(1'b1, 4'd10, 32'h44, 1'b1);
        cyc();
        check("fw_latch", 64'(if14.double_mem_wr_en), 64'd0);
        drive14(1'b1, 4'd11, 32'h45, 1'b1);
        cyc();
        check("fw_wr_en", 64'(if14.double_mem_wr_en), 64'd1);
        check("fw_addr",  64'(if14.double_mem_wr_addr), 64'd5);
        check("fw_din",   if14.double_mem_din, {32'h44, 32'h45});

        // Flushed write of the last pair raises pack_done
        drive14(1'b1, 4'd12, 32'h33, 1'b0);
        cyc();
        check("ld_latch", 64'(if14.double_mem_wr_en), 64'd0);
        drive14(1'b0, 4'd0, 32'h0, 1'b1);
        cyc();
        check("ld_wr_en", 64'(if14.double_mem_wr_en), 64'd1);
        check("ld_addr",  64'(if14.double_mem_wr_addr), 64'd6);
        check("ld_din",   if14.double_mem_din, {32'h33, 32'h0});
        check("ld_done",  64'(if14.pack_done), 64'd1);

        // Async reset while HALF holds word 0
        drive14(1'b1, 4'd0, 32'h55, 1'b0);
        cyc();
        drive14(1'b0, 4'd0, 32'h0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("ar_wr_en", 64'(if14.double_mem_wr_en), 64'd0);
        check("ar_addr",  64'(if14.double_mem_wr_addr), 64'd0);
        check("ar_din",   if14.double_mem_din, 64'd0);
        check("ar_done",  64'(if14.pack_done), 64'd0);
        check("ar_err",   64'(if14.pack_err), 64'd0);
        #1;
        rst = 1'b1;
        cyc();
        check("ar_discard", 64'(if14.double_mem_wr_en), 64'd0);
        drive14(1'b1, 4'd1, 32'h66, 1'b0);
        cyc();
        check("ar_orph_wr_en", 64'(if14.double_mem_wr_en), 64'd0);
        check("ar_orph_err",   64'(if14.pack_err), 64'd1);
        check("ar_orph_din",   if14.double_mem_din, 64'd0);
        drive14(1'b0, 4'd0, 32'h0, 1'b0);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
